// File: rtl/cmsdk_ahb_fill_master.sv
// AHB-Lite master that fills a word-aligned region with a constant or incrementing pattern.
// Define AHB_FILL_VERIFY_EN to add a read-back pass that compares every word after the writes.
module cmsdk_ahb_fill_master #(
  parameter int AW = 16,
  parameter int CW = 16
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [CW-1:0] word_count,
  input  logic [31:0]   pattern,
  input  logic          incr_mode,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    fsm_state,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic [2:0]    HSIZE,
  output logic          HWRITE,
  output logic [31:0]   HWDATA,
  input  logic          HREADY,
  input  logic [31:0]   HRDATA,
  input  logic          HRESP
);

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
`ifdef AHB_FILL_VERIFY_EN
    ST_VERIFY = 2'd2,
`endif
    ST_DONE   = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] a_rem;      // address phases not yet accepted, including the one on the bus
  logic [31:0]   cur_data;   // word belonging to the address phase currently on the bus
  logic          dp_valid;   // a data phase is in progress
  logic          incr_lat;
  logic [AW-1:0] next_addr;

`ifdef AHB_FILL_VERIFY_EN
  logic [AW-1:0] base_lat;
  logic [CW-1:0] count_lat;
  logic [31:0]   pattern_lat;
  logic [31:0]   exp_data;
  logic          unused_inputs;
  assign unused_inputs = ^base_addr[1:0];
`else
  logic          unused_inputs;
  assign unused_inputs = ^{base_addr[1:0], HRDATA};
`endif

  assign HSIZE     = 3'b010;
  assign fsm_state = state;
  assign next_addr = HADDR + AW'(4);

  // Handshake: an address phase is accepted on a rising edge with HTRANS[1]=1 and HREADY=1;
  // the matching data phase completes on the next rising edge with HREADY=1.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      HADDR    <= '0;
      HTRANS   <= HT_IDLE;
      HWRITE   <= 1'b0;
      HWDATA   <= '0;
      a_rem    <= '0;
      cur_data <= '0;
      dp_valid <= 1'b0;
      incr_lat <= 1'b0;
`ifdef AHB_FILL_VERIFY_EN
      base_lat    <= '0;
      count_lat   <= '0;
      pattern_lat <= '0;
      exp_data    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            err      <= 1'b0;
            incr_lat <= incr_mode;
            dp_valid <= 1'b0;
`ifdef AHB_FILL_VERIFY_EN
            base_lat    <= {base_addr[AW-1:2], 2'b00};
            count_lat   <= word_count;
            pattern_lat <= pattern;
`endif
            if (word_count == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state    <= ST_WRITE;
              busy     <= 1'b1;
              HADDR    <= {base_addr[AW-1:2], 2'b00};
              HTRANS   <= HT_NONSEQ;
              HWRITE   <= 1'b1;
              a_rem    <= word_count;
              cur_data <= pattern;
            end
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          if (dp_valid && HRESP) begin
            // Two-cycle ERROR: drop the pending address phase now, finish on the second cycle.
            HTRANS <= HT_IDLE;
            a_rem  <= '0;
            err    <= 1'b1;
            if (HREADY) begin
              dp_valid <= 1'b0;
              HWRITE   <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= ST_DONE;
            end
          end else if (HREADY) begin
`ifdef AHB_FILL_VERIFY_EN
            if (dp_valid && !HWRITE && (HRDATA != exp_data)) err <= 1'b1;
`endif
            if (HTRANS[1]) begin
              dp_valid <= 1'b1;
              if (HWRITE) HWDATA <= cur_data;
`ifdef AHB_FILL_VERIFY_EN
              exp_data <= cur_data;
`endif
              cur_data <= incr_lat ? cur_data + 32'd1 : cur_data;
              a_rem    <= a_rem - CW'(1);
              if (a_rem > CW'(1)) begin
                HADDR  <= next_addr;
                HTRANS <= (next_addr[9:2] == 8'd0) ? HT_NONSEQ : HT_SEQ;
              end else begin
                HTRANS <= HT_IDLE;
              end
            end else begin
              dp_valid <= 1'b0;
              if (dp_valid) begin
`ifdef AHB_FILL_VERIFY_EN
                if (state == ST_WRITE) begin
                  state    <= ST_VERIFY;
                  HADDR    <= base_lat;
                  HTRANS   <= HT_NONSEQ;
                  HWRITE   <= 1'b0;
                  a_rem    <= count_lat;
                  cur_data <= pattern_lat;
                end else begin
                  state  <= ST_DONE;
                  HWRITE <= 1'b0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                end
`else
                state  <= ST_DONE;
                HWRITE <= 1'b0;
                busy   <= 1'b0;
                done   <= 1'b1;
`endif
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmsdk_ahb_fill_master.sv
// Bench for cmsdk_ahb_fill_master: table of fill runs against a waited/erroring AHB RAM model,
// plus hand sequences for zero count, start while busy, ERROR response, mid-run reset and read-back.
module tb_cmsdk_ahb_fill_master;
  localparam int AW = 16;
  localparam int CW = 16;
`ifdef AHB_FILL_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic [31:0]   pattern = '0;
  logic          incr_mode = 1'b0;
  logic          HREADY = 1'b1;
  logic          HRESP = 1'b0;
  logic [31:0]   HRDATA = '0;
  logic          busy, done, err, HWRITE;
  logic [1:0]    fsm_state, HTRANS;
  logic [AW-1:0] HADDR;
  logic [2:0]    HSIZE;
  logic [31:0]   HWDATA;

  cmsdk_ahb_fill_master #(.AW(AW), .CW(CW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .base_addr(base_addr),
    .word_count(word_count), .pattern(pattern), .incr_mode(incr_mode),
    .busy(busy), .done(done), .err(err), .fsm_state(fsm_state),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  // ---------------- clock / reset ----------------
  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- slave model + scoreboard ----------------
  typedef struct { logic [AW-1:0] addr; logic [1:0] trans; logic wr; } aent_t;
  aent_t         alog[$];
  logic [31:0]   exp_q[$];
  logic [31:0]   mem[int];
  int            wait_n = 0, err_word = -1, corrupt_word = -1;
  int            w_idx = 0, r_idx = 0;
  bit            sp_pend = 0, sp_write = 0, in_wait = 0;
  int            sp_word = 0, sp_ws = 0, sp_err_cyc = 0;
  logic [AW-1:0] sp_addr = '0, hold_addr = '0;
  logic [1:0]    hold_trans = '0;
  logic [31:0]   hold_wdata = '0;

  always @(negedge HCLK) begin
    if (HRESET) begin
      sp_pend = 0; in_wait = 0; sp_err_cyc = 0;
      HREADY = 1'b1; HRESP = 1'b0;
    end else begin
      HREADY = 1'b1; HRESP = 1'b0;
      if (sp_pend) begin
        if (sp_write && sp_word == err_word) begin
          HRESP = 1'b1;
          if (sp_err_cyc == 0) begin HREADY = 1'b0; sp_err_cyc = 1; end
          else begin sp_pend = 0; sp_err_cyc = 0; end
        end else begin
          if (in_wait) begin
            check("wait_haddr", 32'(HADDR), 32'(hold_addr));
            check("wait_htrans", 32'(HTRANS), 32'(hold_trans));
            if (sp_write) check("wait_hwdata", HWDATA, hold_wdata);
          end
          if (sp_ws > 0) begin
            hold_addr = HADDR; hold_trans = HTRANS; hold_wdata = HWDATA;
            in_wait = 1; HREADY = 1'b0; sp_ws--;
          end else begin
            in_wait = 0; sp_pend = 0;
            if (sp_write) begin
              if (exp_q.size() == 0) check("sb_unexpected_write", HWDATA, 32'h0);
              else check("sb_hwdata", HWDATA, exp_q.pop_front());
              mem[int'(sp_addr >> 2)] = (sp_word == corrupt_word) ? (HWDATA ^ 32'h1) : HWDATA;
            end else begin
              HRDATA = mem.exists(int'(sp_addr >> 2)) ? mem[int'(sp_addr >> 2)] : 32'h0;
            end
          end
        end
      end
      if (HREADY && HTRANS[1]) begin
        alog.push_back('{HADDR, HTRANS, HWRITE});
        sp_pend = 1; sp_addr = HADDR; sp_write = HWRITE; sp_ws = wait_n; sp_err_cyc = 0;
        if (HWRITE) begin sp_word = w_idx; w_idx++; end
        else begin sp_word = r_idx; r_idx++; end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge HCLK); #1;
    cyc++;
  endtask

  task automatic prep(input logic [15:0] b, input logic [15:0] c, input logic [31:0] p,
                      input logic inc, input int ws, input int errw);
    mem.delete(); alog.delete(); exp_q.delete();
    w_idx = 0; r_idx = 0; wait_n = ws; err_word = errw; corrupt_word = -1;
    base_addr = b; word_count = c; pattern = p; incr_mode = inc;
    for (int i = 0; i < int'(c); i++)
      if (errw < 0 || i < errw) exp_q.push_back(p + (inc ? 32'(i) : 32'd0));
  endtask

  task automatic launch();
    start = 1'b1;
    @(posedge HCLK); #1;
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_done();
    while (!done && cyc < 500) step();
    check("done_seen", 32'(done), 32'd1);
  endtask

  function automatic int count_writes();
    int n = 0;
    foreach (alog[i]) if (alog[i].wr) n++;
    return n;
  endfunction

  // ---------------- vectors ----------------
  typedef struct {
    logic [15:0] base; logic [15:0] count; logic [31:0] pat; logic incr; int waits;
    int exp_done; logic [15:0] exp_last_addr; logic [31:0] exp_last_data; int exp_nonseq;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int nonseq, d;
    logic [15:0] last_a;

    vecs[0] = '{16'h0100, 16'd4, 32'hA5A5_A5A5, 1'b0, 0,  6, 16'h010C, 32'hA5A5_A5A5, 1};
    vecs[1] = '{16'h03F8, 16'd4, 32'hFFFF_FFFE, 1'b1, 0,  6, 16'h0404, 32'h0000_0001, 2};
    vecs[2] = '{16'h0203, 16'd3, 32'h0000_0010, 1'b1, 2, 11, 16'h0208, 32'h0000_0012, 1};
    vecs[3] = '{16'hFFF8, 16'd4, 32'h1234_5678, 1'b0, 1, 10, 16'h0004, 32'h1234_5678, 2};
    vecs[4] = '{16'h0000, 16'd1, 32'hDEAD_BEEF, 1'b1, 0,  3, 16'h0000, 32'hDEAD_BEEF, 1};

    // reset state
    HRESET = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_htrans", 32'(HTRANS), 32'd0);
    check("rst_haddr", 32'(HADDR), 32'd0);
    check("rst_hwrite", 32'(HWRITE), 32'd0);
    check("rst_hwdata", HWDATA, 32'd0);
    check("rst_hsize", 32'(HSIZE), 32'd2);
    check("rst_state", 32'(fsm_state), 32'd0);
    HRESET = 1'b0;
    step();

    // table-driven fill runs
    for (int i = 0; i < 5; i++) begin
      prep(vecs[i].base, vecs[i].count, vecs[i].pat, vecs[i].incr, vecs[i].waits, -1);
      launch();
      check("c1_busy", 32'(busy), 32'd1);
      check("c1_htrans", 32'(HTRANS), 32'h2);
      check("c1_haddr", 32'(HADDR), 32'(vecs[i].base & 16'hFFFC));
      check("c1_hwrite", 32'(HWRITE), 32'd1);
      wait_done();
      d = vecs[i].exp_done;
      check("done_cycle", 32'(cyc), 32'(VERIFY ? 2 * d - 1 : d));
      check("busy_at_done", 32'(busy), 32'd0);
      check("err_at_done", 32'(err), 32'd0);
      nonseq = 0; last_a = '0;
      foreach (alog[j]) if (alog[j].wr) begin
        if (alog[j].trans == 2'b10) nonseq++;
        last_a = alog[j].addr;
      end
      check("write_count", 32'(count_writes()), 32'(vecs[i].count));
      check("nonseq_count", 32'(nonseq), 32'(vecs[i].exp_nonseq));
      check("last_addr", 32'(last_a), 32'(vecs[i].exp_last_addr));
      check("last_data", mem.exists(int'(vecs[i].exp_last_addr >> 2)) ?
            mem[int'(vecs[i].exp_last_addr >> 2)] : 32'hxxxx_xxxx, vecs[i].exp_last_data);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      step();
      check("done_one_cycle", 32'(done), 32'd0);
      check("back_to_idle", 32'(fsm_state), 32'd0);
    end

    // zero word count: done one cycle after start, no bus activity
    prep(16'h0040, 16'd0, 32'h1, 1'b0, 0, -1);
    launch();
    check("z_done", 32'(done), 32'd1);
    check("z_busy", 32'(busy), 32'd0);
    check("z_htrans", 32'(HTRANS), 32'd0);
    step();
    check("z_done_clear", 32'(done), 32'd0);
    check("z_no_xfer", 32'(alog.size()), 32'd0);

    // start while busy is ignored
    prep(16'h0100, 16'd4, 32'h0000_0011, 1'b0, 0, -1);
    launch();
    step();
    base_addr = 16'h0800; word_count = 16'd2; pattern = 32'h99; start = 1'b1;
    step();
    start = 1'b0;
    wait_done();
    check("bz_done_cycle", 32'(cyc), VERIFY ? 32'd11 : 32'd6);
    check("bz_writes", 32'(count_writes()), 32'd4);
    check("bz_no_second_run", 32'(mem.exists(int'(16'h0800 >> 2))), 32'd0);
    check("bz_sb_empty", 32'(exp_q.size()), 32'd0);
    step();

    // ERROR response on word 2 (third word)
    prep(16'h0100, 16'd6, 32'h0000_0050, 1'b1, 0, 2);
    launch();
    repeat (3) step();
    check("e_c4_htrans", 32'(HTRANS), 32'h3);
    check("e_c4_err", 32'(err), 32'd0);
    step();
    check("e_c5_htrans_idle", 32'(HTRANS), 32'd0);
    check("e_c5_err", 32'(err), 32'd1);
    check("e_c5_busy", 32'(busy), 32'd1);
    wait_done();
    check("e_done_cycle", 32'(cyc), 32'd6);
    check("e_err_at_done", 32'(err), 32'd1);
    check("e_addr_phases", 32'(count_writes()), 32'd3);
    check("e_word2_unwritten", 32'(mem.exists(int'(16'h0108 >> 2))), 32'd0);
    check("e_sb_empty", 32'(exp_q.size()), 32'd0);
    step();
    check("e_err_sticky", 32'(err), 32'd1);
    prep(16'h0100, 16'd1, 32'h0000_0001, 1'b0, 0, -1);
    launch();
    check("e_err_cleared", 32'(err), 32'd0);
    wait_done();
    step();

    // reset in the middle of a run
    prep(16'h0100, 16'd8, 32'h0000_0077, 1'b0, 1, -1);
    launch();
    repeat (3) step();
    HRESET = 1'b1;
    step();
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    check("mr_err", 32'(err), 32'd0);
    check("mr_htrans", 32'(HTRANS), 32'd0);
    check("mr_haddr", 32'(HADDR), 32'd0);
    check("mr_hwrite", 32'(HWRITE), 32'd0);
    check("mr_hwdata", HWDATA, 32'd0);
    check("mr_state", 32'(fsm_state), 32'd0);
    HRESET = 1'b0;
    step();

`ifdef AHB_FILL_VERIFY_EN
    // read-back pass flags a corrupted word but still issues every read
    prep(16'h0100, 16'd4, 32'h0000_1000, 1'b1, 0, -1);
    corrupt_word = 1;
    launch();
    wait_done();
    check("v_done_cycle", 32'(cyc), 32'd11);
    check("v_err", 32'(err), 32'd1);
    check("v_reads", 32'(alog.size() - count_writes()), 32'd4);
    corrupt_word = -1;
    step();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
